eth_rx_mac_filter: RTL and testbench
====================================

ETH_RX_MAC_FILTER -- requirements
Module: eth_rx_mac_filter

Interface
REQ-001 SHALL have parameter axis_req_t, default eth_top_pkg::s_req_t, AXI-stream request type (64-bit tdata, 8-bit tkeep/tstrb, 1-bit tuser).
REQ-002 SHALL have parameter axis_rsp_t, default eth_top_pkg::s_rsp_t, AXI-stream response type (tready).
REQ-003 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have ports: rx_axis_req_i in axis_req_t frames from the MAC RX path; rx_axis_rsp_o out axis_rsp_t.
REQ-005 SHALL have ports: tx_axis_req_o out axis_req_t filtered frames to the consumer; tx_axis_rsp_i in axis_rsp_t.
REQ-006 SHALL have ports: mac_addr_i in 48 station address, byte0 in [7:0]; promisc_i in 1 accept all; mcast_en_i in 1 accept multicast.
REQ-007 SHALL have ports: stats_clr_i in 1 counter clear; pass_cnt_o out 32 accepted frames; drop_cnt_o out 32 dropped frames.

Function
REQ-008 SHALL treat tdata[47:0] of a frame's first beat as the destination MAC, byte0 = tdata[7:0].
REQ-009 SHALL accept a frame if promisc_i, or dest == mac_addr_i, or dest == 48'hFFFF_FFFF_FFFF, or (mcast_en_i and tdata[0] == 1).
REQ-010 SHALL drop any frame whose first beat has tlast=1 and tkeep[5:0] != 6'h3F (runt), regardless of REQ-009.
REQ-011 SHALL use FSM states IDLE (awaiting first beat), PASS, DROP; reset state IDLE.
REQ-012 IDLE: on input handshake with tlast=0 go PASS if accepted else DROP; with tlast=1 stay IDLE.
REQ-013 PASS/DROP: on input handshake with tlast=1 return to IDLE; otherwise hold state.
REQ-014 SHALL sample mac_addr_i, promisc_i, mcast_en_i only on the first-beat handshake; mid-frame changes SHALL NOT affect the current frame.
REQ-015 SHALL forward accepted beats unmodified (all fields) through one output register: latency exactly 1 cycle.
REQ-016 SHALL assert rx tready = 1 in DROP and on a dropped first beat in IDLE; otherwise rx tready = !out_valid | tx tready (full throughput, no bubbles).
REQ-017 SHALL hold tx_axis_req_o stable while tvalid=1 and tready=0 (AXI-stream rule).
REQ-018 SHALL never emit a partial frame: dropped frames produce zero output beats.
REQ-019 Back-to-back frames (tlast then new first beat next cycle) SHALL be filtered independently with no lost cycles.

Reset
REQ-020 On rst_ni low: state IDLE, tx tvalid 0, output data register 0, counters 0, rx tready 0 while in reset.
REQ-021 Reset mid-frame SHALL discard the in-flight frame; the first beat after reset release is treated as a frame start.

Configuration
REQ-022 Macro ETH_RX_FILTER_STATS_EN defined: pass_cnt_o/drop_cnt_o increment by 1 on the tlast handshake of each accepted/dropped frame (runt counts as drop), wrap at 2^32, cleared synchronously by stats_clr_i (clear wins over increment).
REQ-023 Macro undefined: ports remain, pass_cnt_o/drop_cnt_o tied to 0, no counter flops, stats_clr_i ignored.

Structure
REQ-024 eth_top_pkg SHALL gain typedef mac_addr_t (logic [47:0]) and localparam BroadcastMac = 48'hFFFF_FFFF_FFFF.
REQ-025 FSM state enum SHALL be local to the module; no sub-module, output register implemented inline.

Verification
REQ-026 mac_addr_i=02:00:00:00:00:01, 3-beat frame to that dest, tx tready=1 -> 3 identical beats out, each 1 cycle later; pass_cnt_o=1.
REQ-027 Frame dest 02:00:00:00:00:99, promisc_i=0 -> zero output beats, rx tready=1 throughout, drop_cnt_o=1; repeat with promisc_i=1 -> frame passes.
REQ-028 Dest 01:00:5E:00:00:01 with mcast_en_i=0 then 1 -> dropped then passed; dest FF:FF:FF:FF:FF:FF -> always passed.
REQ-029 Single beat tlast=1, tkeep=8'h0F, matching dest -> dropped, drop_cnt_o increments.
REQ-030 tx tready toggled randomly over 100 back-to-back frames -> output stable while stalled, byte-exact order, no beat loss or duplication.
REQ-031 rst_ni asserted on beat 2 of a 4-beat passing frame -> tvalid 0 immediately, counters 0; next frame after release filtered correctly.

Source files
------------

// File: rtl/eth_top_pkg.sv
// Shared Ethernet stream types: AXI-stream request/response structs, MAC address type,
// and the destination-address acceptance rules used by the RX filter.
package eth_top_pkg;

  typedef logic [47:0] mac_addr_t;

  localparam mac_addr_t BroadcastMac = 48'hFFFF_FFFF_FFFF;

  typedef struct packed {
    logic [63:0] tdata;
    logic [7:0]  tstrb;
    logic [7:0]  tkeep;
    logic        tuser;
    logic        tlast;
    logic        tvalid;
  } s_req_t;

  typedef struct packed {
    logic tready;
  } s_rsp_t;

  // Byte0 of the destination sits in [7:0], so the group bit is dest[0].
  function automatic logic mac_accept(input mac_addr_t dest, input mac_addr_t station,
                                      input logic promisc, input logic mcast_en);
    return promisc || (dest == station) || (dest == BroadcastMac) || (mcast_en && dest[0]);
  endfunction

  function automatic logic is_runt(input logic tlast, input logic [7:0] tkeep);
    return tlast && (tkeep[5:0] != 6'h3F);
  endfunction

endpackage

// File: rtl/eth_rx_mac_filter_if.sv
// AXI-stream bundle (request + response struct) with master/slave views,
// used to wire the filter's stream ports.
interface eth_rx_mac_filter_if #(
  parameter type req_t = eth_top_pkg::s_req_t,
  parameter type rsp_t = eth_top_pkg::s_rsp_t
) ();

  req_t req;
  rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);

endinterface

// File: rtl/eth_rx_mac_filter.sv
// RX destination-MAC filter: decides per frame on the first beat, forwards accepted beats
// through one output register. Frame counters exist only with ETH_RX_FILTER_STATS_EN defined.
module eth_rx_mac_filter
  import eth_top_pkg::*;
#(
  parameter type axis_req_t = eth_top_pkg::s_req_t,
  parameter type axis_rsp_t = eth_top_pkg::s_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  axis_req_t   rx_axis_req_i,
  output axis_rsp_t   rx_axis_rsp_o,
  output axis_req_t   tx_axis_req_o,
  input  axis_rsp_t   tx_axis_rsp_i,
  input  mac_addr_t   mac_addr_i,
  input  logic        promisc_i,
  input  logic        mcast_en_i,
  input  logic        stats_clr_i,
  output logic [31:0] pass_cnt_o,
  output logic [31:0] drop_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DROP
  } state_e;

  state_e    state_q, state_d;
  axis_req_t out_q, out_d;

  logic out_free;
  logic first_pass;
  logic drop_beat;
  logic rx_ready;
  logic rx_hs;
  logic fwd_beat;

  // The config inputs only influence the first beat; afterwards the state carries the verdict.
  always_comb begin
    out_free   = !out_q.tvalid || tx_axis_rsp_i.tready;
    first_pass = mac_accept(rx_axis_req_i.tdata[47:0], mac_addr_i, promisc_i, mcast_en_i) &&
                 !is_runt(rx_axis_req_i.tlast, rx_axis_req_i.tkeep);
    drop_beat  = (state_q == DROP) || ((state_q == IDLE) && !first_pass);
    rx_ready   = rst_ni && (drop_beat || out_free);
    rx_hs      = rx_axis_req_i.tvalid && rx_ready;
    fwd_beat   = rx_hs && !drop_beat;

    state_d = state_q;
    if (rx_hs) begin
      if (rx_axis_req_i.tlast) begin
        state_d = IDLE;
      end else if (state_q == IDLE) begin
        state_d = first_pass ? PASS : DROP;
      end
    end

    out_d = out_q;
    if (fwd_beat) begin
      out_d = rx_axis_req_i;
    end else if (out_free) begin
      out_d.tvalid = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    rx_axis_rsp_o        = '0;
    rx_axis_rsp_o.tready = rx_ready;
  end

  assign tx_axis_req_o = out_q;

`ifdef ETH_RX_FILTER_STATS_EN
  logic [31:0] pass_cnt_q;
  logic [31:0] drop_cnt_q;

  // Each frame is counted once, on its tlast handshake; a clear takes priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else if (stats_clr_i) begin
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (rx_hs && rx_axis_req_i.tlast && !drop_beat) begin
        pass_cnt_q <= pass_cnt_q + 32'd1;
      end
      if (rx_hs && rx_axis_req_i.tlast && drop_beat) begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  assign pass_cnt_o = pass_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`else
  logic unused_stats_clr;

  assign unused_stats_clr = stats_clr_i;
  assign pass_cnt_o       = '0;
  assign drop_cnt_o       = '0;
`endif

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Self-checking bench for eth_rx_mac_filter: directed scenarios plus randomized back-to-back
// traffic, checked against a frame-level acceptance model.
module tb_eth_rx_mac_filter;
  import eth_top_pkg::*;

`ifdef ETH_RX_FILTER_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  s_req_t      rxReq = '0;
  logic        txReady = 1'b1;
  mac_addr_t   macAddr = '0;
  logic        promisc = 1'b0;
  logic        mcastEn = 1'b0;
  logic        statsClr = 1'b0;
  logic [31:0] passCnt;
  logic [31:0] dropCnt;

  int checks = 0;
  int errors = 0;

  s_req_t frameQ[$];
  s_req_t expQ[$];
  s_req_t gotQ[$];
  int     gotCycQ[$];
  int     hsCycQ[$];
  int     modelPass = 0;
  int     modelDrop = 0;
  int     readyLow = 0;
  int     stallViol = 0;
  int     cyc = 0;
  bit     randTx = 1'b0;
  bit     prevStalled = 1'b0;
  s_req_t prevReq = '0;

  always #5 clk = ~clk;

  eth_rx_mac_filter_if #(.req_t(s_req_t), .rsp_t(s_rsp_t)) rxIf ();
  eth_rx_mac_filter_if #(.req_t(s_req_t), .rsp_t(s_rsp_t)) txIf ();

  assign rxIf.req        = rxReq;
  assign txIf.rsp.tready = txReady;

  eth_rx_mac_filter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rx_axis_req_i(rxIf.req),
    .rx_axis_rsp_o(rxIf.rsp),
    .tx_axis_req_o(txIf.req),
    .tx_axis_rsp_i(txIf.rsp),
    .mac_addr_i   (macAddr),
    .promisc_i    (promisc),
    .mcast_en_i   (mcastEn),
    .stats_clr_i  (statsClr),
    .pass_cnt_o   (passCnt),
    .drop_cnt_o   (dropCnt)
  );

  // Cycle index and output collector; beats are recorded mid-cycle when they will be consumed.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prevStalled <= 1'b0;
    end else begin
      if (prevStalled && (txIf.req !== prevReq)) stallViol <= stallViol + 1;
      if (txIf.req.tvalid && txReady) begin
        gotQ.push_back(txIf.req);
        gotCycQ.push_back(cyc);
      end
      prevStalled <= txIf.req.tvalid && !txReady;
      prevReq     <= txIf.req;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (randTx) txReady = 1'($urandom_range(0, 1));
  endtask

  task automatic build_frame(input mac_addr_t dest, input int nBeats, input logic [7:0] lastKeep);
    s_req_t beat;
    frameQ.delete();
    for (int i = 0; i < nBeats; i++) begin
      beat       = '0;
      beat.tdata = {$urandom, $urandom};
      if (i == 0) beat.tdata[47:0] = dest;
      beat.tkeep  = (i == nBeats - 1) ? lastKeep : 8'hFF;
      beat.tstrb  = 8'($urandom);
      beat.tuser  = 1'($urandom);
      beat.tlast  = (i == nBeats - 1);
      beat.tvalid = 1'b1;
      frameQ.push_back(beat);
    end
  endtask

  // Frame-level reference: verdict from the first beat and the config at frame start.
  task automatic model_frame();
    mac_addr_t dest;
    bit runt, ok;
    dest = frameQ[0].tdata[47:0];
    runt = (frameQ.size() == 1) && (frameQ[0].tkeep[5:0] != 6'h3F);
    ok   = !runt && (promisc || dest == macAddr || dest == 48'hFFFF_FFFF_FFFF || (mcastEn && dest[0]));
    if (ok) begin
      foreach (frameQ[i]) expQ.push_back(frameQ[i]);
      modelPass++;
    end else begin
      modelDrop++;
    end
  endtask

  task automatic send_frame(input bit scramble, output bit timedOut);
    int waitCyc;
    bit rdy;
    timedOut = 1'b0;
    model_frame();
    for (int i = 0; i < frameQ.size(); i++) begin
      waitCyc = 0;
      rxReq   = frameQ[i];
      do begin
        @(negedge clk);
        rdy = rxIf.rsp.tready;
        if (!rdy) readyLow++;
        tick();
        waitCyc++;
      end while (!rdy && waitCyc < 500);
      if (!rdy) begin
        timedOut = 1'b1;
        break;
      end
      hsCycQ.push_back(cyc);
      if (i == 0 && scramble) begin
        macAddr = 48'({$urandom, $urandom});
        promisc = 1'($urandom);
        mcastEn = 1'($urandom);
      end
    end
    rxReq = '0;
  endtask

  task automatic wait_drain(input int base, output bit timedOut);
    int c;
    c = 0;
    while ((gotQ.size() - base) < expQ.size() && c < 3000) begin
      tick();
      c++;
    end
    timedOut = (gotQ.size() - base) < expQ.size();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (txIf.req !== '0) begin
      errors++;
      $display("[TB] FAIL reset_out: got %h want 0", txIf.req);
    end
    checks++;
    if (rxIf.rsp.tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rx_ready: got %b want 0", rxIf.rsp.tready);
    end
    checks++;
    if (passCnt !== 32'd0 || dropCnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_counters: got %0d/%0d want 0/0", passCnt, dropCnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unicast();
    int base;
    bit to, dr;
    randTx  = 1'b0;
    txReady = 1'b1;
    macAddr = 48'h01_00_00_00_00_02;
    promisc = 1'b0;
    mcastEn = 1'b0;
    base    = gotQ.size();
    hsCycQ.delete();
    build_frame(48'h01_00_00_00_00_02, 3, 8'hFF);
    send_frame(1'b0, to);
    wait_drain(base, dr);
    checks++;
    if (to || dr || (gotQ.size() - base) != 3) begin
      errors++;
      $display("[TB] FAIL unicast_count: got %0d beats (timeout %b/%b) want 3", gotQ.size() - base, to, dr);
    end
    for (int i = 0; i < expQ.size() && base + i < gotQ.size(); i++) begin
      checks++;
      if (gotQ[base + i] !== expQ[i]) begin
        errors++;
        $display("[TB] FAIL unicast_beat%0d: got %h want %h", i, gotQ[base + i], expQ[i]);
      end
      checks++;
      if (i < hsCycQ.size() && gotCycQ[base + i] != hsCycQ[i]) begin
        errors++;
        $display("[TB] FAIL unicast_latency%0d: out cycle %0d want %0d", i, gotCycQ[base + i], hsCycQ[i]);
      end
    end
    checks++;
    if (passCnt !== (StatsEn ? 32'(modelPass) : 32'd0)) begin
      errors++;
      $display("[TB] FAIL unicast_pass_cnt: got %0d want %0d", passCnt, StatsEn ? modelPass : 0);
    end
    expQ.delete();
  endtask

  task automatic test_drop_promisc();
    int base;
    bit to1, to2, to3, dr;
    randTx  = 1'b0;
    promisc = 1'b0;
    mcastEn = 1'b0;
    base    = gotQ.size();
    txReady = 1'b0;
    build_frame(48'hFFFF_FFFF_FFFF, 1, 8'hFF);
    send_frame(1'b0, to1);
    readyLow = 0;
    build_frame(48'h99_00_00_00_00_02, 4, 8'hFF);
    send_frame(1'b0, to2);
    checks++;
    if (to2 || readyLow != 0) begin
      errors++;
      $display("[TB] FAIL drop_rx_ready: %0d stalled cycles (timeout %b) want 0", readyLow, to2);
    end
    txReady = 1'b1;
    promisc = 1'b1;
    send_frame(1'b0, to3);
    wait_drain(base, dr);
    checks++;
    if (to1 || to3 || dr || (gotQ.size() - base) != expQ.size()) begin
      errors++;
      $display("[TB] FAIL drop_count: got %0d beats want %0d", gotQ.size() - base, expQ.size());
    end
    for (int i = 0; i < expQ.size() && base + i < gotQ.size(); i++) begin
      checks++;
      if (gotQ[base + i] !== expQ[i]) begin
        errors++;
        $display("[TB] FAIL drop_beat%0d: got %h want %h", i, gotQ[base + i], expQ[i]);
      end
    end
    checks++;
    if (dropCnt !== (StatsEn ? 32'(modelDrop) : 32'd0)) begin
      errors++;
      $display("[TB] FAIL drop_cnt: got %0d want %0d", dropCnt, StatsEn ? modelDrop : 0);
    end
    promisc = 1'b0;
    expQ.delete();
  endtask

  task automatic test_multicast();
    int base;
    bit to, dr, anyTo;
    randTx  = 1'b0;
    txReady = 1'b1;
    promisc = 1'b0;
    anyTo   = 1'b0;
    base    = gotQ.size();
    mcastEn = 1'b0;
    build_frame(48'h01_00_00_5E_00_01, 2, 8'h3F);
    send_frame(1'b0, to); anyTo |= to;
    mcastEn = 1'b1;
    build_frame(48'h01_00_00_5E_00_01, 2, 8'h3F);
    send_frame(1'b0, to); anyTo |= to;
    mcastEn = 1'b0;
    build_frame(48'hFFFF_FFFF_FFFF, 3, 8'h01);
    send_frame(1'b0, to); anyTo |= to;
    wait_drain(base, dr);
    checks++;
    if (anyTo || dr || (gotQ.size() - base) != expQ.size()) begin
      errors++;
      $display("[TB] FAIL mcast_count: got %0d beats want %0d", gotQ.size() - base, expQ.size());
    end
    for (int i = 0; i < expQ.size() && base + i < gotQ.size(); i++) begin
      checks++;
      if (gotQ[base + i] !== expQ[i]) begin
        errors++;
        $display("[TB] FAIL mcast_beat%0d: got %h want %h", i, gotQ[base + i], expQ[i]);
      end
    end
    expQ.delete();
  endtask

  task automatic test_runt();
    int base;
    bit to, dr, anyTo;
    randTx  = 1'b0;
    txReady = 1'b1;
    macAddr = 48'h01_00_00_00_00_02;
    promisc = 1'b0;
    mcastEn = 1'b0;
    anyTo   = 1'b0;
    base    = gotQ.size();
    build_frame(48'h01_00_00_00_00_02, 1, 8'h0F);
    send_frame(1'b0, to); anyTo |= to;
    build_frame(48'h01_00_00_00_00_02, 1, 8'h3F);
    send_frame(1'b0, to); anyTo |= to;
    build_frame(48'hFFFF_FFFF_FFFF, 1, 8'h1F);
    send_frame(1'b0, to); anyTo |= to;
    promisc = 1'b1;
    build_frame(48'h01_00_00_00_00_02, 1, 8'hEF);
    send_frame(1'b0, to); anyTo |= to;
    promisc = 1'b0;
    wait_drain(base, dr);
    checks++;
    if (anyTo || dr || (gotQ.size() - base) != expQ.size()) begin
      errors++;
      $display("[TB] FAIL runt_count: got %0d beats want %0d", gotQ.size() - base, expQ.size());
    end
    for (int i = 0; i < expQ.size() && base + i < gotQ.size(); i++) begin
      checks++;
      if (gotQ[base + i] !== expQ[i]) begin
        errors++;
        $display("[TB] FAIL runt_beat%0d: got %h want %h", i, gotQ[base + i], expQ[i]);
      end
    end
    checks++;
    if (dropCnt !== (StatsEn ? 32'(modelDrop) : 32'd0) || passCnt !== (StatsEn ? 32'(modelPass) : 32'd0)) begin
      errors++;
      $display("[TB] FAIL runt_counters: got %0d/%0d want %0d/%0d", passCnt, dropCnt,
               StatsEn ? modelPass : 0, StatsEn ? modelDrop : 0);
    end
    expQ.delete();
  endtask

  task automatic test_back_to_back();
    int base, stallBase, n;
    bit to, dr, anyTo;
    mac_addr_t dest;
    logic [7:0] lastKeep;
    anyTo     = 1'b0;
    base      = gotQ.size();
    stallBase = stallViol;
    randTx    = 1'b1;
    for (int f = 0; f < 100; f++) begin
      macAddr    = 48'({$urandom, $urandom});
      macAddr[0] = 1'b0;
      promisc    = ($urandom_range(0, 3) == 0);
      mcastEn    = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       dest = macAddr;
        1:       dest = 48'hFFFF_FFFF_FFFF;
        2:       begin dest = 48'({$urandom, $urandom}); dest[0] = 1'b1; end
        default: begin dest = 48'({$urandom, $urandom}); dest[0] = 1'b0; end
      endcase
      n = $urandom_range(1, 4);
      case ($urandom_range(0, 3))
        0:       lastKeep = 8'hFF;
        1:       lastKeep = 8'h3F;
        2:       lastKeep = 8'h0F;
        default: lastKeep = 8'($urandom_range(1, 255));
      endcase
      build_frame(dest, n, lastKeep);
      send_frame(1'b1, to);
      anyTo |= to;
    end
    randTx  = 1'b0;
    txReady = 1'b1;
    wait_drain(base, dr);
    checks++;
    if (anyTo || dr || (gotQ.size() - base) != expQ.size()) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d beats want %0d", gotQ.size() - base, expQ.size());
    end
    for (int i = 0; i < expQ.size() && base + i < gotQ.size(); i++) begin
      checks++;
      if (gotQ[base + i] !== expQ[i]) begin
        errors++;
        $display("[TB] FAIL b2b_beat%0d: got %h want %h", i, gotQ[base + i], expQ[i]);
      end
    end
    checks++;
    if (stallViol != stallBase) begin
      errors++;
      $display("[TB] FAIL b2b_stall_stable: %0d changes while stalled want 0", stallViol - stallBase);
    end
    checks++;
    if (passCnt !== (StatsEn ? 32'(modelPass) : 32'd0) || dropCnt !== (StatsEn ? 32'(modelDrop) : 32'd0)) begin
      errors++;
      $display("[TB] FAIL b2b_counters: got %0d/%0d want %0d/%0d", passCnt, dropCnt,
               StatsEn ? modelPass : 0, StatsEn ? modelDrop : 0);
    end
    expQ.delete();
    statsClr = 1'b1;
    tick();
    statsClr  = 1'b0;
    modelPass = 0;
    modelDrop = 0;
    checks++;
    if (passCnt !== 32'd0 || dropCnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL stats_clear: got %0d/%0d want 0/0", passCnt, dropCnt);
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    bit to, dr, anyTo;
    randTx  = 1'b0;
    txReady = 1'b1;
    macAddr = 48'h01_00_00_00_00_02;
    promisc = 1'b0;
    mcastEn = 1'b0;
    anyTo   = 1'b0;
    tick();
    base = gotQ.size();
    build_frame(48'h01_00_00_00_00_02, 4, 8'hFF);
    rxReq = frameQ[0];
    tick();
    rxReq = frameQ[1];
    tick();
    rxReq = frameQ[2];
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (txIf.req.tvalid !== 1'b0 || rxIf.rsp.tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: tvalid %b rx_ready %b want 0/0", txIf.req.tvalid, rxIf.rsp.tready);
    end
    checks++;
    if (passCnt !== 32'd0 || dropCnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL midreset_counters: got %0d/%0d want 0/0", passCnt, dropCnt);
    end
    checks++;
    if ((gotQ.size() - base) != 1 || gotQ[gotQ.size() - 1] !== frameQ[0]) begin
      errors++;
      $display("[TB] FAIL midreset_partial: got %0d beats before reset want 1 (beat0)", gotQ.size() - base);
    end
    rxReq     = '0;
    modelPass = 0;
    modelDrop = 0;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    base = gotQ.size();
    build_frame(48'h99_00_00_00_00_02, 3, 8'hFF);
    send_frame(1'b0, to); anyTo |= to;
    build_frame(48'h01_00_00_00_00_02, 2, 8'h7F);
    send_frame(1'b0, to); anyTo |= to;
    wait_drain(base, dr);
    checks++;
    if (anyTo || dr || (gotQ.size() - base) != expQ.size()) begin
      errors++;
      $display("[TB] FAIL postreset_count: got %0d beats want %0d", gotQ.size() - base, expQ.size());
    end
    for (int i = 0; i < expQ.size() && base + i < gotQ.size(); i++) begin
      checks++;
      if (gotQ[base + i] !== expQ[i]) begin
        errors++;
        $display("[TB] FAIL postreset_beat%0d: got %h want %h", i, gotQ[base + i], expQ[i]);
      end
    end
    checks++;
    if (passCnt !== (StatsEn ? 32'(modelPass) : 32'd0) || dropCnt !== (StatsEn ? 32'(modelDrop) : 32'd0)) begin
      errors++;
      $display("[TB] FAIL postreset_counters: got %0d/%0d want %0d/%0d", passCnt, dropCnt,
               StatsEn ? modelPass : 0, StatsEn ? modelDrop : 0);
    end
    expQ.delete();
  endtask

  initial begin
    $display("[TB] eth_rx_mac_filter bench start (stats %0d)", StatsEn);
    test_reset();
    test_unicast();
    test_drop_promisc();
    test_multicast();
    test_runt();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
